xbar_arbiter: RTL and testbench
===============================

Name: xbar_arbiter

Overview:
Request arbiter and mux-select controller for the 2-master / 2-slave cross_bar. Each master presents a request with a target slave, chosen by address bit 31. For each slave the block grants one master at a time using round-robin priority. It drives the per-slave master-select lines and per-master grants into cross_bar. It also holds each grant until the transaction ends, and releases a stuck grant via a watchdog timeout.

Parameters:
TMO_CYC, 64, watchdog limit in cycles while a slave is BUSY; 0 disables the watchdog.
CNT_W, 8, watchdog counter width; must satisfy TMO_CYC <= 2**CNT_W - 1.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req  in  2  req[m]: master m requests a transaction; held high until gnt[m]
tsel  in  2  tsel[m]: target slave of master m (addr[31]); valid while req[m]=1
done  in  2  done[m]: one-cycle pulse, master m finished its current transaction
gnt  out  2  gnt[m]: master m owns its target slave
slv_src  out  2  slv_src[s]: index of the master driving slave s (the cross_bar mux select)
slv_vld  out  2  slv_vld[s]: slave s is owned; slv_src[s] is meaningful
tmo_err  out  2  tmo_err[s]: one-cycle pulse, grant on slave s was forcibly released

Behaviour:
- Reset: gnt=0, slv_src=0, slv_vld=0, tmo_err=0, both FSMs IDLE, round-robin pointer rr[s]=0 (master 0 has priority), watchdog counters=0. A reset mid-transaction drops all grants at that edge. The aborted transaction is not reported.
- Candidate set for slave s: every m with req[m]=1, tsel[m]=s and gnt[m]=0.
- Per-slave FSM, two states:
  - IDLE:
    - If the candidate set is non-empty, pick the winner at the clock edge.
    - The winner is the sole candidate. If both masters are candidates, the winner is master rr[s].
    - Then set slv_src[s]=winner, slv_vld[s]=1, gnt[winner]=1, rr[s]=~winner, counter=0, and go to BUSY.
    - Latency: req sampled in cycle n gives gnt high in cycle n+1.
  - BUSY:
    - If done[slv_src[s]]=1: clear gnt, clear slv_vld[s] and go to IDLE. slv_src[s] holds its last value.
    - Else if TMO_CYC!=0 and counter==TMO_CYC-1: same release, plus tmo_err[s]=1 for one cycle.
    - Else counter+1, saturating.
    - done from the non-owning master is ignored.
- Turnaround: at least one IDLE cycle between consecutive grants on one slave, so slv_vld drops for ≥1 cycle. Back-to-back requests by the same master are therefore always separated by one gap cycle.
- One master can hold at most one grant. Its tsel is captured when the grant is issued; tsel changes while granted are ignored.
- Both slaves run independently. Two masters targeting different slaves are granted in the same cycle, with no interaction.
- A req dropped before its grant is withdrawn silently.
- The rr[s] pointer is updated only on a contested grant or an uncontested grant, never on release.
- done and a new req in the same cycle: release takes effect first, and the new grant is evaluated in the following IDLE cycle.
- If done and the timeout coincide, done wins: tmo_err is not pulsed.
- A done pulse while gnt[m]=0 is ignored.

Test Plan:
1. Reset, then req=01 with tsel[0]=0 at cycle 0 -> gnt=01, slv_vld=01, slv_src[0]=0 at cycle 1. Then done=01 at cycle 3 -> gnt=00 and slv_vld=00 at cycle 4.
2. Contention: req=11 with tsel=00, held -> gnt=01 first. After done[0], IDLE for 1 cycle, then gnt=10 and slv_src[0]=1. After the next done[1] with req=11 -> gnt=01 (round-robin alternation over 8 transactions: 0,1,0,1,...).
3. Parallel: req=11 with tsel[0]=0 and tsel[1]=1 -> gnt=11, slv_vld=11, slv_src[0]=0 and slv_src[1]=1 in the same cycle. Then done=10 only -> gnt=01 next cycle.
4. Watchdog, TMO_CYC=4: grant to master 1 on slave 1, no done -> tmo_err[1]=1 and gnt[1]=0 exactly 4 cycles after the grant. Pending master 0 on slave 1 is granted one cycle later. Rerun with done on cycle 4 -> no tmo_err.
5. Reset mid-operation: rst asserted while both slaves are BUSY -> all outputs 0 next edge. After release with req=11 and tsel=00 -> master 0 wins (rr reset).
6. Noise: done[1] while only master 0 is granted, and tsel[0] toggled during the grant -> no state change, slv_src stable. A req withdrawn before its grant -> no gnt.

Source files
------------

// File: rtl/xbar_arbiter.sv
// xbar_arbiter: request arbiter and mux-select controller for the 2x2 cross_bar.
// Each slave has its own IDLE/BUSY FSM. The FSM grants one requesting master with
// round-robin priority and holds that grant until the owner pulses done. A watchdog
// forces the release of a grant that stays held for too long.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous reset, active-high
//   req_i[m]     master m requests a transaction (held until gnt_o[m])
//   tsel_i[m]    target slave of master m (addr[31]), valid while req_i[m]
//   done_i[m]    one-cycle pulse, master m finished its transaction
//   gnt_o[m]     master m owns its target slave
//   slv_src_o[s] master index driving slave s (cross_bar mux select)
//   slv_vld_o[s] slave s is owned, slv_src_o[s] is meaningful
//   tmo_err_o[s] one-cycle pulse, grant on slave s was forcibly released
module xbar_arbiter #(
    parameter int unsigned TMO_CYC = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic [1:0] tsel_i,
    input  logic [1:0] done_i,
    output logic [1:0] gnt_o,
    output logic [1:0] slv_src_o,
    output logic [1:0] slv_vld_o,
    output logic [1:0] tmo_err_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Counter value seen in the last allowed BUSY cycle.
    localparam logic [CNT_W-1:0] TMO_LAST = (TMO_CYC == 0) ? '0 : CNT_W'(TMO_CYC - 1);

    state_e           state_q [2];
    state_e           state_d [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    logic [1:0]       src_q, src_d;
    logic [1:0]       rr_q, rr_d;
    logic [1:0]       tmo_q, tmo_d;
    logic [1:0]       cand    [2];
    logic [1:0]       win;
    logic [1:0]       busy;
    logic [1:0]       gnt;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned s = 0; s < 2; s++) begin
                state_q[s] <= IDLE;
                cnt_q[s]   <= '0;
            end
            src_q <= '0;
            rr_q  <= '0;
            tmo_q <= '0;
        end else begin
            for (int unsigned s = 0; s < 2; s++) begin
                state_q[s] <= state_d[s];
                cnt_q[s]   <= cnt_d[s];
            end
            src_q <= src_d;
            rr_q  <= rr_d;
            tmo_q <= tmo_d;
        end
    end

    // Next-state logic
    always_comb begin
        src_d = src_q;
        rr_d  = rr_q;
        tmo_d = '0;
        win   = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            state_d[s] = state_q[s];
            cnt_d[s]   = cnt_q[s];
            cand[s]    = '0;
            // A master already holding a grant is never a candidate, so it can
            // own at most one slave at a time.
            for (int unsigned m = 0; m < 2; m++) begin
                cand[s][m] = req_i[m] && (tsel_i[m] == 1'(s)) && !gnt[m];
            end
            case (state_q[s])
                IDLE: begin
                    if (cand[s] != '0) begin
                        win[s]     = (cand[s] == 2'b11) ? rr_q[s] : cand[s][1];
                        src_d[s]   = win[s];
                        rr_d[s]    = ~win[s];
                        cnt_d[s]   = '0;
                        state_d[s] = BUSY;
                    end
                end
                BUSY: begin
                    // done has priority over the watchdog: a coinciding timeout is silent.
                    if (done_i[src_q[s]]) begin
                        state_d[s] = IDLE;
                    end else if ((TMO_CYC != 0) && (cnt_q[s] == TMO_LAST)) begin
                        state_d[s] = IDLE;
                        tmo_d[s]   = 1'b1;
                    end else if (cnt_q[s] != '1) begin
                        cnt_d[s] = cnt_q[s] + CNT_W'(1);
                    end
                end
                default: state_d[s] = IDLE;
            endcase
        end
    end

    // Output logic: grants are decoded from the owning slave's select.
    always_comb begin
        busy = '0;
        gnt  = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            busy[s] = (state_q[s] == BUSY);
            if (busy[s]) begin
                gnt[src_q[s]] = 1'b1;
            end
        end
    end

    assign gnt_o     = gnt;
    assign slv_vld_o = busy;
    assign slv_src_o = src_q;
    assign tmo_err_o = tmo_q;

endmodule

// File: tb/tb_xbar_arbiter.sv
// tb_xbar_arbiter: directed bench for xbar_arbiter (watchdog limit 4 cycles).
// A per-slave ownership model (owner, age, priority) predicts every output each
// cycle; hand-computed literal expectations pin the directed scenarios.
module tb_xbar_arbiter;

    localparam int TMO = 4;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] tsel;
    logic [1:0] done;
    logic [1:0] gnt;
    logic [1:0] slv_src;
    logic [1:0] slv_vld;
    logic [1:0] tmo_err;

    int errors;
    int checks;
    bit chk_en;
    int n;

    // Model state
    int own  [2];   // owning master, -1 when free
    int age  [2];   // cycles the current owner has held the slave
    int prio [2];   // master preferred on a tie
    int msrc [2];   // last granted master
    int mtmo [2];   // watchdog pulse
    bit held [2];
    int ncand;
    int lastc;
    logic [1:0] eg, ev, es, et;

    xbar_arbiter #(
        .TMO_CYC(TMO),
        .CNT_W  (8)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .tsel_i   (tsel),
        .done_i   (done),
        .gnt_o    (gnt),
        .slv_src_o(slv_src),
        .slv_vld_o(slv_vld),
        .tmo_err_o(tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: advance one clock using the inputs present at the edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                own[s] = -1; age[s] = 0; prio[s] = 0; msrc[s] = 0; mtmo[s] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) held[m] = (own[0] == m) || (own[1] == m);
            for (int s = 0; s < 2; s++) begin
                mtmo[s] = 0;
                if (own[s] >= 0) begin
                    if (done[own[s]]) begin
                        own[s] = -1;
                    end else if (TMO != 0 && age[s] == TMO) begin
                        own[s] = -1;
                        mtmo[s] = 1;
                    end else begin
                        age[s] = age[s] + 1;
                    end
                end else begin
                    ncand = 0;
                    lastc = 0;
                    for (int m = 0; m < 2; m++) begin
                        if (req[m] && (tsel[m] == s[0]) && !held[m]) begin
                            ncand++;
                            lastc = m;
                        end
                    end
                    if (ncand > 0) begin
                        own[s]  = (ncand == 2) ? prio[s] : lastc;
                        msrc[s] = own[s];
                        prio[s] = 1 - own[s];
                        age[s]  = 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            eg = '0;
            for (int s = 0; s < 2; s++) begin
                if (own[s] >= 0) eg[own[s]] = 1'b1;
                ev[s] = (own[s] >= 0);
                es[s] = (msrc[s] != 0);
                et[s] = (mtmo[s] != 0);
            end
            chk("mdl_gnt", gnt, eg);
            chk("mdl_vld", slv_vld, ev);
            chk("mdl_src", slv_src, es);
            chk("mdl_tmo", tmo_err, et);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0; chk_en = 0;
        rst = 1'b1; req = '0; tsel = '0; done = '0;
        @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_vld", slv_vld, 2'b00);
        chk("rst_src", slv_src, 2'b00);
        chk("rst_tmo", tmo_err, 2'b00);
        rst = 1'b0;

        // 1: single request, grant next cycle, release on done
        req = 2'b01; tsel = 2'b00;
        @(negedge clk);
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_vld", slv_vld, 2'b01);
        chk("t1_src", slv_src, 2'b00);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("t1_hold", gnt, 2'b01);
        done = 2'b01;
        @(negedge clk);
        done = 2'b00;
        chk("t1_rel_gnt", gnt, 2'b00);
        chk("t1_rel_vld", slv_vld, 2'b00);

        // 2: contention on slave 0, round-robin over 8 transactions
        do_reset();
        req = 2'b11; tsel = 2'b00;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (gnt == 2'b00 && n < 6);
            chk("t2_gap", 8'(n), 8'd1);
            chk("t2_order", gnt, (i % 2 == 1) ? 2'b10 : 2'b01);
            chk("t2_src0", {7'd0, slv_src[0]}, (i % 2 == 1) ? 8'd1 : 8'd0);
            done = gnt;
            @(negedge clk);
            done = 2'b00;
            chk("t2_turn", slv_vld, 2'b00);
        end
        req = 2'b00;
        @(negedge clk);

        // 3: parallel grants on different slaves
        req = 2'b11; tsel = 2'b10;
        @(negedge clk);
        chk("t3_gnt", gnt, 2'b11);
        chk("t3_vld", slv_vld, 2'b11);
        chk("t3_src", slv_src, 2'b10);
        req = 2'b00; done = 2'b10;
        @(negedge clk);
        chk("t3_part", gnt, 2'b01);
        chk("t3_pvld", slv_vld, 2'b01);
        done = 2'b01;
        @(negedge clk);
        done = 2'b00;
        chk("t3_end", gnt, 2'b00);

        // 4: watchdog on slave 1, pending master 0 granted after it
        req = 2'b10; tsel = 2'b10;
        @(negedge clk);
        chk("t4_gnt", gnt, 2'b10);
        req = 2'b01; tsel = 2'b11;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("t4_hold", gnt, 2'b10);
            chk("t4_notmo", tmo_err, 2'b00);
        end
        @(negedge clk);
        chk("t4_tmo", tmo_err, 2'b10);
        chk("t4_rel", gnt, 2'b00);
        chk("t4_vld", slv_vld, 2'b00);
        @(negedge clk);
        chk("t4_next_gnt", gnt, 2'b01);
        chk("t4_next_src", slv_src, 2'b00);
        chk("t4_next_vld", slv_vld, 2'b10);
        chk("t4_pulse", tmo_err, 2'b00);
        req = 2'b00; done = 2'b01;
        @(negedge clk);
        done = 2'b00;
        chk("t4_clr", gnt, 2'b00);
        // done coinciding with the watchdog limit wins
        req = 2'b10; tsel = 2'b10;
        @(negedge clk);
        chk("t4b_gnt", gnt, 2'b10);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        done = 2'b10;
        @(negedge clk);
        done = 2'b00;
        chk("t4b_rel", gnt, 2'b00);
        chk("t4b_notmo", tmo_err, 2'b00);
        @(negedge clk);
        chk("t4b_notmo2", tmo_err, 2'b00);

        // 5: reset while both slaves busy, priority returns to master 0
        req = 2'b11; tsel = 2'b10;
        @(negedge clk);
        chk("t5_both", gnt, 2'b11);
        req = 2'b00; rst = 1'b1;
        @(negedge clk);
        chk("t5_rgnt", gnt, 2'b00);
        chk("t5_rvld", slv_vld, 2'b00);
        chk("t5_rsrc", slv_src, 2'b00);
        chk("t5_rtmo", tmo_err, 2'b00);
        rst = 1'b0; req = 2'b11; tsel = 2'b00;
        @(negedge clk);
        chk("t5_rr", gnt, 2'b01);
        req = 2'b10; done = 2'b01;
        @(negedge clk);
        done = 2'b00;
        chk("t5_gap", gnt, 2'b00);
        @(negedge clk);
        chk("t5_m1", gnt, 2'b10);
        chk("t5_m1src", slv_src, 2'b01);
        req = 2'b00; done = 2'b10;
        @(negedge clk);
        done = 2'b00;

        // 6: foreign done, tsel change while granted, withdrawn request
        req = 2'b01; tsel = 2'b00;
        @(negedge clk);
        chk("t6_gnt", gnt, 2'b01);
        req = 2'b10; tsel = 2'b01; done = 2'b10;
        @(negedge clk);
        chk("t6_noise_gnt", gnt, 2'b01);
        chk("t6_noise_src", slv_src, 2'b00);
        chk("t6_noise_vld", slv_vld, 2'b01);
        done = 2'b00; req = 2'b00; tsel = 2'b00;
        @(negedge clk);
        chk("t6_stable", gnt, 2'b01);
        done = 2'b01;
        @(negedge clk);
        done = 2'b00;
        chk("t6_rel", gnt, 2'b00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_withdrawn", gnt, 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
